// File: rtl/kab_interval_timer.sv
// Register-mapped down-counting interval timer with prescaler, auto-reload and a level interrupt.
// Sits on the I/O register bus and feeds one request line of the external interrupt controller.
module kab_interval_timer #(
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic        Sys_BlockSelect,
  input  logic [3:0]  Sys_RegAddress,
  input  logic        Sys_WrEn,
  input  logic        Sys_RdEn,
  input  logic [31:0] Sys_WrData,
  output logic [31:0] Sys_RdData,
  output logic        IntReq
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_LOAD   = 4'd1;
  localparam logic [3:0] ADDR_COUNT  = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } timerStateT;

  timerStateT       state, stateNext;
  logic [CNT_W-1:0] count, countNext;
  logic [CNT_W-1:0] loadVal, loadNext;
  logic [PRE_W-1:0] pre, preNext;
  logic             ctrlAuto, autoNext;
  logic             ctrlIe, ieNext;
  logic             expFlag, expNext;
  logic [31:0]      rdMux, rdNext;

  logic wrAccess, rdAccess;
  logic ctrlWr, loadWr, statusWr;
  logic tick, expire;

  assign wrAccess = Sys_BlockSelect & Sys_WrEn;
  assign rdAccess = Sys_BlockSelect & Sys_RdEn;
  assign ctrlWr   = wrAccess && (Sys_RegAddress == ADDR_CTRL);
  assign loadWr   = wrAccess && (Sys_RegAddress == ADDR_LOAD);
  assign statusWr = wrAccess && (Sys_RegAddress == ADDR_STATUS);
  assign tick     = (state == RUN) && (pre == PRE_LAST);

  // State register and all timer/bus registers
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state      <= STOP;
      count      <= '0;
      loadVal    <= '0;
      pre        <= '0;
      ctrlAuto   <= 1'b0;
      ctrlIe     <= 1'b0;
      expFlag    <= 1'b0;
      Sys_RdData <= '0;
    end else begin
      state      <= stateNext;
      count      <= countNext;
      loadVal    <= loadNext;
      pre        <= preNext;
      ctrlAuto   <= autoNext;
      ctrlIe     <= ieNext;
      expFlag    <= expNext;
      Sys_RdData <= rdNext;
    end
  end

  // Next-state: a stop write takes priority over a coincident tick
  always_comb begin
    stateNext = state;
    countNext = count;
    loadNext  = loadVal;
    preNext   = pre;
    autoNext  = ctrlAuto;
    ieNext    = ctrlIe;
    expNext   = expFlag;
    expire    = 1'b0;

    if (ctrlWr) begin
      autoNext = Sys_WrData[1];
      ieNext   = Sys_WrData[2];
    end
    if (loadWr) begin
      loadNext = Sys_WrData[CNT_W-1:0];
    end

    unique case (state)
      STOP: begin
        preNext = '0;
        if (ctrlWr && Sys_WrData[0]) begin
          stateNext = RUN;
          countNext = loadVal;
        end
      end
      RUN: begin
        if (ctrlWr && !Sys_WrData[0]) begin
          stateNext = STOP;
          preNext   = '0;
        end else begin
          preNext = tick ? '0 : pre + PRE_W'(1);
          if (tick) begin
            if (count != '0) begin
              countNext = count - CNT_W'(1);
            end else begin
              expire = 1'b1;
              if (ctrlAuto) begin
                countNext = loadVal;
              end else begin
                stateNext = STOP;
                countNext = '0;
              end
            end
          end
        end
      end
    endcase

    if (statusWr && Sys_WrData[0]) begin
      expNext = 1'b0;
    end
    if (expire) begin
      expNext = 1'b1;
    end
  end

  // Read path returns pre-edge values; idle cycles drive zero onto the bus
  always_comb begin
    rdMux = '0;
    unique case (Sys_RegAddress)
      ADDR_CTRL:   rdMux = 32'({ctrlIe, ctrlAuto, (state == RUN)});
      ADDR_LOAD:   rdMux = 32'(loadVal);
      ADDR_COUNT:  rdMux = 32'(count);
      ADDR_STATUS: rdMux = 32'(expFlag);
      default:     rdMux = '0;
    endcase
    rdNext = rdAccess ? rdMux : '0;
  end

  assign IntReq = expFlag & ctrlIe;

endmodule

// File: doc/kab_interval_timer.md
# kab_interval_timer

Programmable down-counting interval timer that occupies one reserved block slot of the I/O subsystem. It is register-mapped on the processor-side I/O register bus, decoded by block select plus a 4-bit register address. It drives one interrupt request line into the external interrupt controller's request vector. It sits directly upstream of the interrupt controller as one of its interrupt sources.

## Interface
- PRESCALE, 16: system clocks per timer tick; legal range 1..65536.
- CNT_W, 32: counter and reload width; legal range 1..32.

- Sys_Clock  in  1  system clock; all logic is on the rising edge.
- Sys_Reset  in  1  synchronous reset, active-high.
- Sys_BlockSelect  in  1  this block is addressed.
- Sys_RegAddress  in  4  register index.
- Sys_WrEn  in  1  write strobe, qualified by Sys_BlockSelect.
- Sys_RdEn  in  1  read strobe, qualified by Sys_BlockSelect.
- Sys_WrData  in  32  write data.
- Sys_RdData  out  32  read data, registered.
- IntReq  out  1  level interrupt request to the EIC.

## Operation
- Registers, selected by Sys_RegAddress:
  - 0 CTRL, RW: bit0 EN, bit1 AUTO (auto-reload), bit2 IE; other bits read 0.
  - 1 LOAD, RW: reload value, CNT_W bits, zero-extended on read.
  - 2 COUNT, RO: current counter value; writes are ignored.
  - 3 STATUS: bit0 EXP; writing 1 clears it, writing 0 has no effect.
  - 4..15: reserved; reads return 0 and writes are ignored.
- Prescaler: counter Pre counts 0..PRESCALE-1. A tick fires in the cycle where Pre == PRESCALE-1, and Pre returns to 0. Pre is held at 0 while not running.
- State machine (STOP, RUN):
  - STOP -> RUN on a CTRL write with EN=1 while in STOP. That write also sets COUNT <= LOAD (the new LOAD value if written in the same cycle is not possible, since there is one register per access) and Pre <= 0.
  - RUN, tick with COUNT != 0: COUNT <= COUNT-1.
  - RUN, tick with COUNT == 0: set EXP. If AUTO, COUNT <= LOAD and stay in RUN. Otherwise clear EN, go to STOP, and hold COUNT at 0.
  - RUN -> STOP on a CTRL write with EN=0. COUNT freezes at its value.
  - A CTRL write with EN=1 while already in RUN updates AUTO/IE only. It does not restart the counter.
- Writes to LOAD while running take effect at the next reload only.
- IntReq = EXP & IE, combinational from registered bits, so it is glitch-free. It stays asserted until software clears EXP or IE.
- Simultaneous expiry and EXP clear in the same cycle: set wins, so EXP stays 1.
- LOAD = 0: expiry happens on every tick.
- Read: Sys_RdData is valid the cycle after a Sys_RdEn & Sys_BlockSelect cycle. In any other cycle Sys_RdData = 0, so the upstream OR/mux stays clean. A COUNT read returns the value before that edge's update.
- Write and read in the same cycle to the same register: the read returns the old value.

## Timing
- Reset values: CTRL = 0, LOAD = 0, COUNT = 0, EXP = 0, Pre = 0, state STOP, Sys_RdData = 0, IntReq = 0.
- Reset mid-count returns all registers to their reset values in the next cycle. No pending interrupt survives reset.
- Enable write at edge t: COUNT = LOAD visible from t+1.
  - First tick at edge t+PRESCALE.
  - EXP sets at edge t+(LOAD+1)*PRESCALE.
  - IntReq rises in the same cycle EXP sets, if IE is set.
- Auto-reload period: (LOAD+1)*PRESCALE cycles between EXP set events.
- Write latency: a register update is visible at the next edge. Read latency: 1 cycle.
- Arithmetic: COUNT decrement never underflows, because the zero case is handled by the expiry rule. Pre width is clog2(PRESCALE), minimum 1 bit.

## Test plan
- Reset then read all registers 0..15 -> every read returns 0; IntReq = 0.
- PRESCALE=4, LOAD=3, CTRL=0b101 (EN, IE, one-shot) written at cycle t -> IntReq rises at t+16; CTRL.EN reads 0; COUNT reads 0; no further activity over 64 cycles.
- LOAD=2, CTRL=0b111 (auto) -> EXP set events every 12 cycles. After writing STATUS=1, IntReq drops the next cycle and reasserts 12 cycles after the previous expiry.
- Write STATUS=1 in the exact cycle of expiry -> EXP remains 1 and IntReq stays high.
- Running with LOAD=5: write LOAD=1 mid-count -> the current period completes at 24 cycles, the next periods are 8 cycles. Write CTRL EN=0 -> COUNT frozen across 20 cycles.
- Assert Sys_Reset while IntReq is high and COUNT is mid-run -> next cycle all registers and IntReq are 0. Re-enabling restarts from LOAD = 0.
